// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: SRAM-like data bus between the M-stage load/store engine and memory
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store engine on an SRAM-like bus; `define ADDR_CHECK_EN enables misalignment exceptions
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memenM,
    input  logic [2:0]        ls_typeM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [31:0]       wdataM,
    input  logic              flushM,
    input  logic              mem_hold,
    output logic              stall_o,
    output logic [31:0]       rdataM,
    output logic              adelM,
    output logic              adesM,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state, nextState;
    logic        isStore, isByte, isHalf, isWord, go, capture;
    logic [15:0] laneData;
    logic [31:0] loadData;

    assign isStore = ls_typeM[2] & |ls_typeM[1:0];
    assign isByte  = ls_typeM == 3'b000 || ls_typeM == 3'b001 || ls_typeM == 3'b101;
    assign isHalf  = ls_typeM == 3'b010 || ls_typeM == 3'b011 || ls_typeM == 3'b110;
    assign isWord  = ~isByte & ~isHalf;

`ifdef ADDR_CHECK_EN
    logic misaligned;
    assign misaligned    = isHalf & addrM[0] | isWord & |addrM[1:0];
    assign adelM         = memenM & ~isStore & misaligned;
    assign adesM         = memenM & isStore & misaligned;
    assign bus.data_addr = addrM;
`else
    // Without exceptions, misaligned accesses are silently aligned down.
    assign adelM         = 1'b0;
    assign adesM         = 1'b0;
    assign bus.data_addr = {addrM[ADDR_W-1:2], addrM[1] & ~isWord, addrM[0] & isByte};
`endif

    assign go             = memenM & ~flushM & ~adelM & ~adesM;
    assign bus.data_wr    = isStore;
    assign bus.data_size  = isByte ? 2'd0 : isHalf ? 2'd1 : 2'd2;
    assign bus.data_wdata = isByte ? {4{wdataM[7:0]}} : isHalf ? {2{wdataM[15:0]}} : wdataM;
    assign laneData       = 16'(bus.data_rdata >> {addrM[1:0], 3'b000});
    assign loadData       = ls_typeM == 3'b000 ? {{24{laneData[7]}}, laneData[7:0]} :
                            ls_typeM == 3'b001 ? {24'b0, laneData[7:0]} :
                            ls_typeM == 3'b010 ? {{16{laneData[15]}}, laneData} :
                            ls_typeM == 3'b011 ? {16'b0, laneData} : bus.data_rdata;

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk)
        state <= rst ? IDLE : nextState;

    // Load result capture on data_ok; held through DONE and beyond.
    always_ff @(posedge clk)
        if (rst) rdataM <= '0;
        else if (capture) rdataM <= loadData;

    // Next state, bus request, stall and capture strobe.
    always_comb begin
        nextState    = state;
        bus.data_req = 1'b0;
        stall_o      = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                bus.data_req = go;
                stall_o      = go;
                if (go) nextState = bus.data_addr_ok ? DATA : ADDR;
            end
            ADDR: begin
                bus.data_req = 1'b1;
                stall_o      = 1'b1;
                capture      = bus.data_addr_ok & bus.data_data_ok;
                if (bus.data_addr_ok) nextState = bus.data_data_ok ? DONE : DATA;
            end
            DATA: begin
                stall_o = 1'b1;
                capture = bus.data_data_ok;
                if (bus.data_data_ok) nextState = DONE;
            end
            DONE: if (!mem_hold) nextState = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a configurable-latency bus slave
module tb_mem_access_unit;
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;
    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } res_t;

    localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011,
                           LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

    logic        clk = 0, rst = 1, memenM = 0, flushM = 0, mem_hold = 0;
    logic [2:0]  ls_typeM = 3'b0;
    logic [31:0] addrM = '0, wdataM = '0;
    logic        stall_o, adelM, adesM;
    logic [31:0] rdataM;

    int          checks = 0, failures = 0, reqCount = 0, waitLeft = 0;
    bit          sameCycle = 0, dataPend = 0, prevStall = 0, prevRst = 1;
    logic [31:0] memData = '0;
    req_t        reqQ[$];
    res_t        resQ[$];
    req_t        r;
    res_t        e;

    mem_access_unit_if #(.ADDR_W(32)) bus();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .ls_typeM(ls_typeM), .addrM(addrM),
        .wdataM(wdataM), .flushM(flushM), .mem_hold(mem_hold), .stall_o(stall_o),
        .rdataM(rdataM), .adelM(adelM), .adesM(adesM), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus slave: addr_ok after waitLeft request cycles, data_ok next cycle or same cycle
    initial begin
        bus.data_addr_ok = 0;
        bus.data_data_ok = 0;
        bus.data_rdata   = '0;
        forever begin
            @(negedge clk);
            bus.data_data_ok = dataPend;
            dataPend         = 0;
            bus.data_addr_ok = 0;
            if (bus.data_req) begin
                if (waitLeft == 0) begin
                    bus.data_addr_ok = 1;
                    if (sameCycle) bus.data_data_ok = 1;
                    else dataPend = 1;
                end else waitLeft--;
            end
            bus.data_rdata = memData;
        end
    end

    // Monitor: pops expected requests on handshakes and expected results on completion
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.data_req && bus.data_addr_ok) begin
                reqCount++;
                if (reqQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected request: addr %h", bus.data_addr);
                end else begin
                    r = reqQ.pop_front();
                    chk("req wr", 32'(bus.data_wr), 32'(r.wr));
                    chk("req size", 32'(bus.data_size), 32'(r.size));
                    chk("req addr", bus.data_addr, r.addr);
                    chk("req wdata", bus.data_wdata, r.wdata);
                end
            end
            if (prevStall && !stall_o && !prevRst) begin
                if (resQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected completion: rdataM %h", rdataM);
                end else begin
                    e = resQ.pop_front();
                    if (e.chk) chk("rdataM", rdataM, e.data);
                end
            end
            prevStall = stall_o;
            prevRst   = rst;
        end
    end

    task automatic doAccess(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int w, input bit same, input int flushAt,
                            input int hold, input logic expWr, input logic [1:0] expSize,
                            input logic [31:0] expAddr, input logic [31:0] expWdata,
                            input bit chkRes, input logic [31:0] expRes, input int expStall);
        int stalls, startReq;
        waitLeft  = w;
        sameCycle = same;
        memData   = rd;
        reqQ.push_back('{expWr, expSize, expAddr, expWdata});
        resQ.push_back('{chkRes, expRes});
        startReq  = reqCount;
        memenM    = 1;
        ls_typeM  = t;
        addrM     = a;
        wdataM    = wd;
        #1;
        stalls = 0;
        while (stall_o && stalls < 30) begin
            if (bus.data_req) chk("addr stable", bus.data_addr, expAddr);
            stalls++;
            flushM = (stalls == flushAt);
            @(posedge clk);
            #1;
        end
        flushM = 0;
        chk("stall cycles", 32'(stalls), 32'(expStall));
        mem_hold = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("held stall", 32'(stall_o), 32'd0);
            if (chkRes) chk("held rdataM", rdataM, expRes);
            if (i == hold - 1) mem_hold = 0;
        end
        memenM = 0;
        @(posedge clk);
        #1;
        chk("idle stall", 32'(stall_o), 32'd0);
        chk("request count", 32'(reqCount - startReq), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset req", 32'(bus.data_req), 32'd0);
        chk("reset rdataM", rdataM, 32'd0);
        chk("reset adel", 32'(adelM), 32'd0);
        chk("reset ades", 32'(adesM), 32'd0);
        rst = 0;
        @(posedge clk);
        #1;
        //       type addr          wdata         rdata         wt sm fl hd wr size addr          wdata         chk res          stalls
        doAccess(LW,  32'h1000, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0, 2'd2, 32'h1000, 32'h0,        1, 32'hDEADBEEF, 2);
        doAccess(LB,  32'h1003, 32'h0,        32'h80112233, 0, 0, 0, 0, 0, 2'd0, 32'h1003, 32'h0,        1, 32'hFFFFFF80, 2);
        doAccess(LBU, 32'h1003, 32'h0,        32'h80112233, 0, 0, 0, 0, 0, 2'd0, 32'h1003, 32'h0,        1, 32'h00000080, 2);
        doAccess(LH,  32'h1002, 32'h0,        32'h80112233, 0, 0, 0, 0, 0, 2'd1, 32'h1002, 32'h0,        1, 32'hFFFF8011, 2);
        doAccess(LHU, 32'h1000, 32'h0,        32'h80118233, 0, 0, 0, 0, 0, 2'd1, 32'h1000, 32'h0,        1, 32'h00008233, 2);
        doAccess(LB,  32'h1001, 32'h0,        32'h00007F00, 0, 0, 0, 0, 0, 2'd0, 32'h1001, 32'h0,        1, 32'h0000007F, 2);
        doAccess(SB,  32'h2001, 32'h123456AB, 32'h0,        0, 0, 0, 0, 1, 2'd0, 32'h2001, 32'hABABABAB, 0, 32'h0,        2);
        doAccess(SH,  32'h2002, 32'h0000BEEF, 32'h0,        0, 0, 0, 0, 1, 2'd1, 32'h2002, 32'hBEEFBEEF, 0, 32'h0,        2);
        doAccess(SW,  32'h2004, 32'hCAFEF00D, 32'h0,        0, 0, 0, 0, 1, 2'd2, 32'h2004, 32'hCAFEF00D, 0, 32'h0,        2);
        doAccess(LW,  32'h3000, 32'h0,        32'h11223344, 3, 0, 0, 0, 0, 2'd2, 32'h3000, 32'h0,        1, 32'h11223344, 5);
        doAccess(LW,  32'h3004, 32'h0,        32'h55667788, 3, 0, 2, 0, 0, 2'd2, 32'h3004, 32'h0,        1, 32'h55667788, 5);
        doAccess(LW,  32'h3008, 32'h0,        32'h0BADF00D, 1, 1, 0, 0, 0, 2'd2, 32'h3008, 32'h0,        1, 32'h0BADF00D, 2);
        doAccess(LW,  32'h4000, 32'h0,        32'hA5A5A5A5, 0, 0, 0, 2, 0, 2'd2, 32'h4000, 32'h0,        1, 32'hA5A5A5A5, 2);

        // Reset in the middle of a stalled request
        waitLeft = 50;
        memenM   = 1;
        ls_typeM = LW;
        addrM    = 32'h5000;
        repeat (2) @(posedge clk);
        #1;
        chk("pre-reset stall", 32'(stall_o), 32'd1);
        rst    = 1;
        memenM = 0;
        @(posedge clk);
        #1;
        rst = 0;
        chk("mid reset stall", 32'(stall_o), 32'd0);
        chk("mid reset req", 32'(bus.data_req), 32'd0);
        chk("mid reset rdataM", rdataM, 32'd0);
        waitLeft = 0;
        @(posedge clk);
        #1;

`ifdef ADDR_CHECK_EN
        begin
            int startReq;
            startReq = reqCount;
            memenM   = 1;
            ls_typeM = LW;
            addrM    = 32'h1002;
            #1;
            chk("adel", 32'(adelM), 32'd1);
            chk("adel ades", 32'(adesM), 32'd0);
            chk("adel req", 32'(bus.data_req), 32'd0);
            chk("adel stall", 32'(stall_o), 32'd0);
            ls_typeM = SH;
            addrM    = 32'h2001;
            wdataM   = 32'h0000BEEF;
            #1;
            chk("ades", 32'(adesM), 32'd1);
            chk("ades adel", 32'(adelM), 32'd0);
            chk("ades req", 32'(bus.data_req), 32'd0);
            chk("ades stall", 32'(stall_o), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            chk("no request on error", 32'(reqCount - startReq), 32'd0);
            memenM = 0;
        end
`else
        doAccess(LW,  32'h1002, 32'h0,        32'h13572468, 0, 0, 0, 0, 0, 2'd2, 32'h1000, 32'h0,        1, 32'h13572468, 2);
        doAccess(SH,  32'h2001, 32'h0000BEEF, 32'h0,        0, 0, 0, 0, 1, 2'd1, 32'h2000, 32'hBEEFBEEF, 0, 32'h0,        2);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("request queue drained", 32'(reqQ.size()), 32'd0);
        chk("result queue drained", 32'(resQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
